image_line_streamer: RTL and testbench
======================================

# image_line_streamer

Source-side AXI4-Stream master that feeds the spatial filter pipeline. It reads an 8-bit grayscale image line by line from a single-port, 1-cycle-latency memory and streams the pixels into the filter's slave port. Line pacing is credit-based: it sends a fixed number of priming lines up front, then one more line per line-buffer-free interrupt from the filter. After the last image line it appends zero padding lines so the filter can flush its final output rows.

## Interface
Parameters:
- IMG_WIDTH, 512, pixels per line (≥2)
- IMG_HEIGHT, 512, image lines (≥PRIME_LINES)
- PRIME_LINES, 4, lines sent after start without waiting for interrupts
- PAD_LINES, 2, all-zero lines appended after the image
- ADDR_W, 18, memory address width (≥ clog2(IMG_WIDTH*IMG_HEIGHT))

Ports:
- axi_clk  in  1  clock; all logic on rising edge
- axi_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse, honoured only in IDLE
- o_busy  out  1  high from accepted start until the final beat is accepted
- o_done  out  1  one-cycle pulse after the final beat is accepted
- o_mem_rd_en  out  1  memory read strobe
- o_mem_addr  out  ADDR_W  linear pixel address, line*IMG_WIDTH + col
- i_mem_data  in  8  read data, valid on the cycle after o_mem_rd_en
- o_data_valid  out  1  AXIS tvalid
- o_data  out  8  AXIS tdata
- o_data_last  out  1  AXIS tlast, high on the last pixel of every line, including pad lines
- i_data_ready  in  1  AXIS tready, driven by the filter's not-prog-full
- i_intr  in  1  filter interrupt; each cycle high is one line credit

## Operation
- States:
  - IDLE: on i_start → SEND; credits := PRIME_LINES; line := 0; col := 0.
  - SEND: issue all IMG_WIDTH reads for the current line; after the last read issue, line++ and → WAIT.
  - WAIT: if line == IMG_HEIGHT+PAD_LINES → DRAIN. Else if credits > 0 → SEND and consume one credit. Credits are also consumed on SEND entry from IDLE.
  - DRAIN: wait until the output FIFO is empty and the last beat is accepted → pulse o_done → IDLE.
- Credits:
  - 3-bit counter, saturating at 7.
  - +1 for each i_intr cycle while o_busy.
  - A simultaneous increment and consume leaves the count unchanged.
  - i_intr is ignored in IDLE.
  - Interrupts after the final line are ignored.
- Read path:
  - 2-entry output FIFO.
  - A read (or pad beat) is issued only when FIFO occupancy plus in-flight beats < 2, or when a pop occurs that cycle.
  - The read result is pushed one cycle later.
  - The col counter wraps from IMG_WIDTH-1 to 0.
- Pad lines (line ≥ IMG_HEIGHT):
  - o_mem_rd_en stays low.
  - Beats of value 0 go through the same FIFO with the same latency.
- o_data_last is carried in the FIFO alongside the data, set when col == IMG_WIDTH-1 at issue.
- AXIS rules:
  - Transfer occurs when o_data_valid && i_data_ready.
  - While valid && !ready, o_data and o_data_last hold stable and valid stays high.
  - Valid never depends combinationally on ready.
- i_start is ignored while o_busy.

## Timing
- Reset state:
  - IDLE, credits 0, FIFO empty.
  - o_busy, o_done, o_mem_rd_en, o_data_valid, o_data_last = 0.
  - o_data = 0, o_mem_addr = 0.
- Start and first beat:
  - i_start sampled in cycle T sets o_busy high at T+1.
  - The first o_mem_rd_en is at T+1 with addr 0.
  - The first o_data_valid is at T+2.
- Throughput:
  - With i_data_ready held high, one beat per cycle within a line.
  - At line boundaries, a bubble of at most 1 cycle when credits are available.
- Line restart: an i_intr in cycle U while in WAIT with credits = 0 gives a first read at U+2 (credit registered, then SEND) and valid at U+3.
- Completion: final beat accepted in cycle F → o_done high and o_busy low at F+1 → IDLE.
- Reset mid-operation: all outputs return to reset values immediately; the next start restarts at address 0.

## Test plan
- Use IMG_WIDTH=4, IMG_HEIGHT=6, PRIME_LINES=4, PAD_LINES=2, mem[a]=a.
- Reset: assert axi_reset_n=0 mid-run → every output 0 asynchronously. After release, i_intr pulses alone → no memory reads, o_busy stays 0.
- Priming: pulse i_start, ready=1 → valid from T+2, beats 0..15 back-to-back. o_data_last on 3, 7, 11, 15. Then valid stays low with o_busy=1.
- Credit lines:
  - One i_intr pulse → beats 16..19.
  - A second pulse → beats 20..23.
  - Two more pulses → eight beats of 0, with last on the 4th and 8th.
  - o_done pulses exactly one cycle after the final accept; o_busy falls with it.
- Backpressure: random i_data_ready (≈50%) over the full run → accepted sequence identical to the ready=1 case. o_data is stable on every stalled cycle, with no drops or duplicates.
- Early credits: three i_intr pulses during priming → lines 4 and 5 plus the first pad line follow without stall. A fourth pulse sends the last pad line. Interrupts after completion have no effect.
- Simultaneous events:
  - i_intr in the same cycle a line consumes a credit → credit count unchanged.
  - i_start while busy → ignored; the beat count for the run stays 32.

Source files
------------

// File: rtl/image_line_streamer.sv
// image_line_streamer: credit-paced AXI4-Stream source that reads an 8-bit image
// line by line from a 1-cycle-latency memory and appends zero pad lines.
module image_line_streamer #(
    parameter int unsigned IMG_WIDTH   = 512,
    parameter int unsigned IMG_HEIGHT  = 512,
    parameter int unsigned PRIME_LINES = 4,
    parameter int unsigned PAD_LINES   = 2,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_data,
    output logic              o_data_valid,
    output logic [7:0]        o_data,
    output logic              o_data_last,
    input  logic              i_data_ready,
    input  logic              i_intr
);
    localparam int unsigned TOTAL_LINES = IMG_HEIGHT + PAD_LINES;
    localparam int unsigned LINE_W      = $clog2(TOTAL_LINES + 1);
    localparam int unsigned COL_W       = $clog2(IMG_WIDTH);
    localparam int unsigned CRED_W      = 3;
    localparam int unsigned CRED_MAX    = 7;
    localparam int unsigned PRIME_SAT   = (PRIME_LINES > CRED_MAX) ? CRED_MAX : PRIME_LINES;
    // The first line is sent straight from IDLE, so it uses up one priming credit.
    localparam logic [CRED_W-1:0] PRIME_CREDITS = CRED_W'(PRIME_SAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DRAIN} state_t;

    state_t              state_q;
    logic [CRED_W-1:0]   credits_q;
    logic [LINE_W-1:0]   line_q;
    logic [COL_W-1:0]    col_q;
    logic [ADDR_W-1:0]   next_addr_q;
    logic                issue_q, iss_last_q, iss_pad_q;
    logic                pend_q, pend_last_q, pend_pad_q;
    logic [7:0]          fifo_data_q [2];
    logic                fifo_last_q [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          count_q;

    logic       head_valid, pop, pop_fifo, push;
    logic [7:0] pend_data;
    logic [2:0] occ;
    logic       can_issue, line_done, credit_take, line_go, issue_go;
    logic       col_last, pad_line, intr_ok, drain_done;

    // Issue/credit decisions and the AXIS head; a beat still in flight from memory is presented directly.
    always_comb begin
        head_valid  = (count_q != 2'd0) || pend_q;
        pop         = head_valid && i_data_ready;
        pop_fifo    = pop && (count_q != 2'd0);
        push        = pend_q && !(pop && (count_q == 2'd0));
        pend_data   = pend_pad_q ? 8'd0 : i_mem_data;
        occ         = 3'(count_q) + 3'(pend_q) + 3'(issue_q);
        can_issue   = (occ < 3'd2) || ((occ == 3'd2) && pop);
        line_done   = (line_q == LINE_W'(TOTAL_LINES));
        credit_take = (state_q == S_WAIT) && !line_done && (credits_q != '0);
        line_go     = ((state_q == S_IDLE) && i_start) || (state_q == S_SEND) || credit_take;
        issue_go    = line_go && can_issue;
        col_last    = (col_q == COL_W'(IMG_WIDTH - 1));
        pad_line    = (line_q >= LINE_W'(IMG_HEIGHT));
        intr_ok     = i_intr && o_busy && !line_done;
        drain_done  = (occ == 3'd0) || ((occ == 3'd1) && pop);
        o_data_valid = head_valid;
        o_data       = 8'd0;
        o_data_last  = 1'b0;
        if (count_q != 2'd0) begin
            o_data      = fifo_data_q[rd_ptr_q];
            o_data_last = fifo_last_q[rd_ptr_q];
        end else if (pend_q) begin
            o_data      = pend_data;
            o_data_last = pend_last_q;
        end
    end

    // Sequencer, read pipeline, output FIFO and line credit counter.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q        <= S_IDLE;
            credits_q      <= '0;
            line_q         <= '0;
            col_q          <= '0;
            next_addr_q    <= '0;
            issue_q        <= 1'b0;
            iss_last_q     <= 1'b0;
            iss_pad_q      <= 1'b0;
            pend_q         <= 1'b0;
            pend_last_q    <= 1'b0;
            pend_pad_q     <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_mem_rd_en    <= 1'b0;
            o_mem_addr     <= '0;
        end else begin
            o_done      <= 1'b0;
            issue_q     <= issue_go;
            o_mem_rd_en <= issue_go && !pad_line;
            if (issue_go) begin
                iss_last_q <= col_last;
                iss_pad_q  <= pad_line;
                if (!pad_line) begin
                    o_mem_addr  <= next_addr_q;
                    next_addr_q <= next_addr_q + ADDR_W'(1);
                end
                if (col_last) begin
                    col_q  <= '0;
                    line_q <= line_q + LINE_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
            pend_q      <= issue_q;
            pend_last_q <= iss_last_q;
            pend_pad_q  <= iss_pad_q;

            if (push) begin
                fifo_data_q[wr_ptr_q] <= pend_data;
                fifo_last_q[wr_ptr_q] <= pend_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_fifo) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop_fifo})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase

            if (state_q == S_IDLE) begin
                if (i_start) begin
                    credits_q <= PRIME_CREDITS;
                end
            end else if ((state_q == S_DRAIN) && drain_done) begin
                credits_q <= '0;
            end else if (intr_ok && !credit_take) begin
                if (credits_q != CRED_W'(CRED_MAX)) begin
                    credits_q <= credits_q + CRED_W'(1);
                end
            end else if (!intr_ok && credit_take) begin
                credits_q <= credits_q - CRED_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_SEND;
                        o_busy  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (issue_go && col_last) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (line_done) begin
                        state_q <= S_DRAIN;
                    end else if (credit_take) begin
                        state_q <= S_SEND;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_q     <= S_IDLE;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        line_q      <= '0;
                        col_q       <= '0;
                        next_addr_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_line_streamer.sv
// Directed bench for image_line_streamer: 4x6 image, 4 priming lines, 2 pad lines, mem[a]=a.
module tb_image_line_streamer;
    localparam int W      = 4;
    localparam int H      = 6;
    localparam int PL     = 4;
    localparam int PAD    = 2;
    localparam int AW     = 8;
    localparam int NBEATS = W * (H + PAD);

    logic          axi_clk = 1'b0;
    logic          axi_reset_n;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic          o_mem_rd_en;
    logic [AW-1:0] o_mem_addr;
    logic [7:0]    i_mem_data = 8'd0;
    logic          o_data_valid;
    logic [7:0]    o_data;
    logic          o_data_last;
    logic          i_data_ready;
    logic          i_intr;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         rd_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    logic       done_busy = 1'b0;
    int         last_acc = -100;
    logic       hold_pend = 1'b0;
    logic [8:0] hold_val = '0;
    logic [8:0] beats[$];
    int         acc_cyc[$];

    image_line_streamer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(PL), .PAD_LINES(PAD), .ADDR_W(AW)
    ) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_mem_rd_en(o_mem_rd_en),
        .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_data_valid(o_data_valid), .o_data(o_data), .o_data_last(o_data_last),
        .i_data_ready(i_data_ready), .i_intr(i_intr)
    );

    always #5 axi_clk = ~axi_clk;

    // Memory model: 1-cycle read latency, contents equal to the address.
    always @(posedge axi_clk) begin
        if (o_mem_rd_en) i_mem_data <= 8'(o_mem_addr);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle (at the falling edge), then advance one cycle.
    task automatic step();
        if (hold_pend) begin
            check("stall_valid", 32'(o_data_valid), 32'd1);
            check("stall_data", 32'({o_data_last, o_data}), 32'(hold_val));
        end
        hold_pend = o_data_valid && !i_data_ready;
        hold_val  = {o_data_last, o_data};
        if (o_data_valid && i_data_ready) begin
            beats.push_back({o_data_last, o_data});
            acc_cyc.push_back(cyc);
            last_acc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = o_busy;
        end
        if (o_mem_rd_en) rd_cnt++;
        @(negedge axi_clk);
        cyc++;
    endtask

    task automatic clear();
        beats.delete();
        acc_cyc.delete();
        hold_pend = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  32'(o_busy), 32'd0);
        check({tag, "_done"},  32'(o_done), 32'd0);
        check({tag, "_rd"},    32'(o_mem_rd_en), 32'd0);
        check({tag, "_addr"},  32'(o_mem_addr), 32'd0);
        check({tag, "_valid"}, 32'(o_data_valid), 32'd0);
        check({tag, "_data"},  32'(o_data), 32'd0);
        check({tag, "_last"},  32'(o_data_last), 32'd0);
    endtask

    task automatic run_beats(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (beats.size() < n && b < budget) begin
            step();
            b++;
        end
        check(tag, 32'(beats.size()), 32'(n));
    endtask

    task automatic check_span(input string tag, input int n);
        if (acc_cyc.size() >= n) check(tag, 32'(acc_cyc[n-1] - acc_cyc[0]), 32'(n - 1));
        else check({tag, "_short"}, 32'(acc_cyc.size()), 32'(n));
    endtask

    task automatic done_checks(input string tag, input int d0);
        check({tag, "_seen"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_timing"}, 32'(done_cyc), 32'(last_acc + 1));
        check({tag, "_busy"}, 32'(done_busy), 32'd0);
        repeat (3) step();
        check({tag, "_single"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic run_done(input string tag, input int budget);
        int d0;
        int b;
        d0 = done_cnt;
        b  = 0;
        while (done_cnt == d0 && b < budget) begin
            step();
            b++;
        end
        done_checks(tag, d0);
    endtask

    task automatic check_seq(input string tag);
        logic [8:0] e;
        check({tag, "_len"}, 32'(beats.size()), 32'(NBEATS));
        for (int i = 0; i < int'(beats.size()) && i < NBEATS; i++) begin
            e[7:0] = (i < W * H) ? 8'(i) : 8'd0;
            e[8]   = ((i % W) == W - 1);
            check($sformatf("%s[%0d]", tag, i), 32'(beats[i]), 32'(e));
        end
    endtask

    task automatic pulse_intr();
        i_intr = 1'b1;
        step();
        i_intr = 1'b0;
    endtask

    initial begin
        int d0;
        axi_reset_n  = 1'b0;
        i_start      = 1'b0;
        i_intr       = 1'b0;
        i_data_ready = 1'b1;
        repeat (3) @(negedge axi_clk);
        check_zero("rst");
        axi_reset_n = 1'b1;
        @(negedge axi_clk);

        // Interrupts while idle must not start anything.
        rd_cnt = 0;
        i_intr = 1'b1;
        repeat (4) step();
        i_intr = 1'b0;
        step();
        check("idle_intr_reads", 32'(rd_cnt), 32'd0);
        check("idle_intr_busy", 32'(o_busy), 32'd0);

        // Run A: ready held high, late credits.
        clear();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("a_t1_busy", 32'(o_busy), 32'd1);
        check("a_t1_rd", 32'(o_mem_rd_en), 32'd1);
        check("a_t1_addr", 32'(o_mem_addr), 32'd0);
        check("a_t1_valid", 32'(o_data_valid), 32'd0);
        step();
        check("a_t2_valid", 32'(o_data_valid), 32'd1);
        check("a_t2_data", 32'(o_data), 32'd0);
        run_beats("a_prime_count", 16, 40);
        check_span("a_prime_span", 16);
        repeat (5) step();
        check("a_prime_idle", 32'(o_data_valid), 32'd0);
        check("a_prime_busy", 32'(o_busy), 32'd1);
        check("a_prime_nomore", 32'(beats.size()), 32'd16);
        pulse_intr();
        check("a_u1_rd", 32'(o_mem_rd_en), 32'd0);
        step();
        check("a_u2_rd", 32'(o_mem_rd_en), 32'd1);
        check("a_u2_addr", 32'(o_mem_addr), 32'd16);
        step();
        check("a_u3_valid", 32'(o_data_valid), 32'd1);
        check("a_u3_data", 32'(o_data), 32'd16);
        run_beats("a_line4_count", 20, 20);
        repeat (4) step();
        check("a_line4_idle", 32'(o_data_valid), 32'd0);
        pulse_intr();
        run_beats("a_line5_count", 24, 20);
        repeat (4) step();
        check("a_line5_idle", 32'(o_data_valid), 32'd0);
        check("a_line5_nomore", 32'(beats.size()), 32'd24);
        pulse_intr();
        step();
        pulse_intr();
        run_done("a_done", 60);
        check_seq("a_seq");

        // Run B: early credits, one coinciding with a credit consume, plus a start while busy.
        clear();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 1; k < 40 && beats.size() < 28; k++) begin
            i_intr  = (k == 4 || k == 7 || k == 10);
            i_start = (k == 8);
            step();
        end
        i_intr  = 1'b0;
        i_start = 1'b0;
        check("b_early_count", 32'(beats.size()), 32'd28);
        check_span("b_early_span", 28);
        repeat (5) step();
        check("b_wait_idle", 32'(o_data_valid), 32'd0);
        check("b_wait_busy", 32'(o_busy), 32'd1);
        check("b_wait_nomore", 32'(beats.size()), 32'd28);
        pulse_intr();
        run_done("b_done", 40);
        check_seq("b_seq");
        rd_cnt = 0;
        i_intr = 1'b1;
        repeat (3) step();
        i_intr = 1'b0;
        repeat (2) step();
        check("b_late_reads", 32'(rd_cnt), 32'd0);
        check("b_late_busy", 32'(o_busy), 32'd0);
        check("b_late_valid", 32'(o_data_valid), 32'd0);

        // Run D: asynchronous reset in the middle of a run.
        clear();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (6) step();
        check("d_pre_busy", 32'(o_busy), 32'd1);
        check("d_pre_valid", 32'(o_data_valid), 32'd1);
        #2 axi_reset_n = 1'b0;
        #1;
        check_zero("d_async");
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        hold_pend   = 1'b0;
        @(negedge axi_clk);
        rd_cnt = 0;
        i_intr = 1'b1;
        repeat (3) step();
        i_intr = 1'b0;
        step();
        check("d_intr_reads", 32'(rd_cnt), 32'd0);
        check("d_intr_busy", 32'(o_busy), 32'd0);

        // Run C: random backpressure, restart from address 0.
        clear();
        i_data_ready = 1'($urandom_range(0, 1));
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("c_t1_busy", 32'(o_busy), 32'd1);
        check("c_t1_rd", 32'(o_mem_rd_en), 32'd1);
        check("c_t1_addr", 32'(o_mem_addr), 32'd0);
        d0 = done_cnt;
        for (int b = 0; b < 400 && done_cnt == d0; b++) begin
            i_intr       = (b == 2 || b == 4 || b == 6 || b == 8);
            i_start      = (b == 5);
            i_data_ready = 1'($urandom_range(0, 1));
            step();
        end
        i_intr       = 1'b0;
        i_start      = 1'b0;
        i_data_ready = 1'b1;
        done_checks("c_done", d0);
        check_seq("c_seq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
